// File: rtl/handshake_result_sink.sv
// handshake_result_sink
//   Consumer end of an elastic valid/ready interface. Accepts a stream of
//   NUM_RESULTS data tokens plus one dataless control (completion) token.
//   Readiness follows a repeating STALL_PATTERN mask to model backpressure.
//   The last accepted payload is kept in result_data. done rises once every
//   expected token has been consumed.
//
//   Optional build macro: HS_SINK_PROTOCOL_CHECK_EN
//     When defined, a sticky protocol_error flag catches two producer faults:
//     a withdrawn token, or a payload that changes while it is stalled.
//     When undefined, protocol_error is tied low and no checker flops exist.
//
// Ports
//   clock           single clock, all state changes on posedge
//   reset           synchronous, active-low reset
//   in_data_valid   producer offers a data token
//   in_data_ready   sink takes a data token this cycle
//   in_data         data token payload
//   in_ctrl_valid   producer offers the control token
//   in_ctrl_ready   sink takes the control token this cycle
//   result_data     payload of the most recently accepted data token
//   result_count    number of data tokens accepted so far
//   ctrl_seen       control token has been accepted
//   done            all expected tokens consumed
//   protocol_error  sticky producer-protocol violation flag
module handshake_result_sink #(
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     NUM_RESULTS   = 1,
   parameter int                     PATTERN_LEN   = 8,
   parameter logic [PATTERN_LEN-1:0] STALL_PATTERN = 8'hFF
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               in_data_valid,
   output logic                               in_data_ready,
   input  logic [DATA_WIDTH-1:0]              in_data,
   input  logic                               in_ctrl_valid,
   output logic                               in_ctrl_ready,
   output logic [DATA_WIDTH-1:0]              result_data,
   output logic [$clog2(NUM_RESULTS+1)-1:0]   result_count,
   output logic                               ctrl_seen,
   output logic                               done,
   output logic                               protocol_error
);

   localparam int CNT_W = $clog2(NUM_RESULTS + 1);
   localparam int PTR_W = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_RESULTS);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PATTERN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t           state;
   logic [PTR_W-1:0] ptr;

   logic             slot_open;
   logic             data_hs;
   logic             ctrl_hs;
   logic [CNT_W-1:0] count_next;
   logic             ctrl_next;

   // Ready is a function of state only, never of valid, so there is no
   // combinational valid->ready path through this block.
   assign slot_open     = (state == S_COLLECT) && STALL_PATTERN[ptr];
   assign in_data_ready = slot_open && (result_count < CNT_MAX);
   assign in_ctrl_ready = slot_open && !ctrl_seen;

   assign data_hs    = in_data_valid && in_data_ready;
   assign ctrl_hs    = in_ctrl_valid && in_ctrl_ready;
   assign count_next = data_hs ? result_count + 1'b1 : result_count;
   assign ctrl_next  = ctrl_seen || ctrl_hs;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= S_IDLE;
         ptr          <= '0;
         result_data  <= '0;
         result_count <= '0;
         ctrl_seen    <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_COLLECT;
            end
            S_COLLECT: begin
               ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
               if (data_hs) begin
                  result_data <= in_data;
               end
               result_count <= count_next;
               ctrl_seen    <= ctrl_next;
               // Completion looks at the post-handshake values so done
               // appears in the cycle right after the final handshake.
               if ((count_next == CNT_MAX) && ctrl_next) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef HS_SINK_PROTOCOL_CHECK_EN
   logic                  data_vld_p1;
   logic                  data_rdy_p1;
   logic                  ctrl_vld_p1;
   logic                  ctrl_rdy_p1;
   logic [DATA_WIDTH-1:0] data_p1;
   logic                  err_flag;
   logic                  data_stalled_p1;
   logic                  ctrl_stalled_p1;
   logic                  violation;

   // A channel counts as stalled when it offered a token last cycle that
   // was not taken; the producer must then keep it offered and unchanged.
   assign data_stalled_p1 = data_vld_p1 && !data_rdy_p1;
   assign ctrl_stalled_p1 = ctrl_vld_p1 && !ctrl_rdy_p1;
   assign violation = (data_stalled_p1 && !in_data_valid)
                   || (ctrl_stalled_p1 && !in_ctrl_valid)
                   || (data_stalled_p1 && in_data_valid && (in_data != data_p1));

   // ---- stage p1: previous-cycle channel snapshot ----
   always_ff @(posedge clock) begin
      if (!reset) begin
         data_vld_p1 <= 1'b0;
         data_rdy_p1 <= 1'b0;
         ctrl_vld_p1 <= 1'b0;
         ctrl_rdy_p1 <= 1'b0;
         err_flag    <= 1'b0;
      end else begin
         data_vld_p1 <= in_data_valid;
         data_rdy_p1 <= in_data_ready;
         ctrl_vld_p1 <= in_ctrl_valid;
         ctrl_rdy_p1 <= in_ctrl_ready;
         if (violation) begin
            err_flag <= 1'b1;
         end
      end
      data_p1 <= in_data;
   end

   assign protocol_error = err_flag;
`else
   assign protocol_error = 1'b0;
`endif

endmodule
